// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared widths and FSM state encoding for the FIFO read-side
//                nibble packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    // S_LO: waiting for the low nibble of a byte.
    // S_HI: low nibble held, waiting for the high nibble.
    typedef enum logic [0:0] {
        S_LO = 1'b0,
        S_HI = 1'b1
    } pack_state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_packer
//  Description : Pops 4-bit nibbles from a show-ahead async-FIFO read port
//                and packs each pair into a byte on a valid/ready stream.
//                The first nibble popped becomes m_data[3:0], the second
//                becomes m_data[7:4].
//  Ports       : rd_clk, rd_rst       - read-domain clock, async high reset
//                fifo_empty/fifo_data - FIFO status and show-ahead data
//                fifo_rd_en           - combinational pop strobe
//                m_valid/m_ready/m_data - registered byte output stream
//                byte_cnt             - wrapping count of accepted bytes
//                m_par                - even parity of m_data (optional)
//  Options     : PACK_PARITY_EN - adds the registered m_par output.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_packer
    import fifo_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                fifo_empty,
    input  logic [NIB_W-1:0]    fifo_data,
    output logic                fifo_rd_en,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BYTE_W-1:0]   m_data,
    output logic [CNT_W-1:0]    byte_cnt
`ifdef PACK_PARITY_EN
    ,
    output logic                m_par
`endif
);

    pack_state_t            r_state;
    pack_state_t            w_state_nxt;
    logic [NIB_W-1:0]       r_lo;
    logic                   r_valid;
    logic [BYTE_W-1:0]      r_data;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_hs;

    // A low nibble can always be taken; the high nibble is only taken when
    // the output register is free or being emptied on this same edge.
    always_comb begin
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_LO: begin
                w_pop = ~rd_rst & ~fifo_empty;
                if (w_pop) begin
                    w_state_nxt = S_HI;
                end
            end
            S_HI: begin
                w_pop  = ~rd_rst & ~fifo_empty & (~r_valid | m_ready);
                w_load = w_pop;
                if (w_pop) begin
                    w_state_nxt = S_LO;
                end
            end
            default: begin
                w_state_nxt = S_LO;
            end
        endcase
    end

    assign w_hs = r_valid & m_ready;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state <= S_LO;
            r_lo    <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop && (r_state == S_LO)) begin
                r_lo <= fifo_data;
            end
            // A new byte loading on a handshake edge keeps m_valid high.
            if (w_load) begin
                r_data  <= {fifo_data, r_lo};
                r_valid <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PACK_PARITY_EN
    logic r_par;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^{fifo_data, r_lo};
        end
    end

    assign m_par = r_par;
`endif

    assign fifo_rd_en = w_pop;
    assign m_valid    = r_valid;
    assign m_data     = r_data;
    assign byte_cnt   = r_cnt;

endmodule : nibble_packer
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_packer
//  Description : Self-checking bench for nibble_packer. A queue models the
//                show-ahead FIFO; expected bytes are formed by pairing the
//                nibbles actually popped since the last reset.
//  Options     : PACK_PARITY_EN - also checks m_par.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_packer;

    localparam int TB_CNT_W = 4;

    logic                rd_clk;
    logic                rd_rst;
    logic                fifo_empty;
    logic [3:0]          fifo_data;
    logic                fifo_rd_en;
    logic                m_valid;
    logic                m_ready;
    logic [7:0]          m_data;
    logic [TB_CNT_W-1:0] byte_cnt;
`ifdef PACK_PARITY_EN
    logic                m_par;
`endif

    nibble_packer #(.CNT_W(TB_CNT_W)) u_dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .byte_cnt   (byte_cnt)
`ifdef PACK_PARITY_EN
        ,
        .m_par      (m_par)
`endif
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    int         n_chk;
    int         n_fail;
    logic [3:0] src_q[$];       // FIFO contents, front = show-ahead word
    logic [7:0] exp_q[$];       // bytes formed but not yet accepted
    bit         have_lo;
    logic [3:0] lo_m;
    int         acc;            // bytes accepted since last reset
    int         n_del;
    logic [7:0] dut_byte;       // last byte the DUT handed over
    int         hs_times[$];
    int         cyc;
    bit         gap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_take(input logic [3:0] n);
        if (!have_lo) begin
            lo_m    = n;
            have_lo = 1'b1;
        end else begin
            exp_q.push_back({n, lo_m});
            have_lo = 1'b0;
        end
    endfunction

    function automatic void model_clear();
        have_lo = 1'b0;
        exp_q.delete();
        acc = 0;
        n_del = 0;
        hs_times.delete();
    endfunction

    task automatic drive_fifo();
        fifo_empty = gap || (src_q.size() == 0);
        fifo_data  = (src_q.size() != 0) ? src_q[0] : 4'($urandom);
    endtask

    // One clock: check outputs at the negedge, then apply the pop/handshake
    // that the following posedge performs to the model.
    task automatic cycle();
        bit   pop;
        bit   hs;
        logic exp_en;
        drive_fifo();
        @(negedge rd_clk);
        exp_en = !fifo_empty && (!have_lo || exp_q.size() == 0 || m_ready);
        check("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_en});
        check("valid", {31'd0, m_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        if (exp_q.size() != 0) begin
            check("data", {24'd0, m_data}, {24'd0, exp_q[0]});
`ifdef PACK_PARITY_EN
            check("par", {31'd0, m_par}, {31'd0, ^exp_q[0]});
`endif
        end
        check("cnt", {28'd0, byte_cnt}, 32'(acc % 16));
        pop = fifo_rd_en;
        hs  = m_valid && m_ready;
        if (hs) dut_byte = m_data;
        @(posedge rd_clk);
        #1;
        cyc++;
        if (hs) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            acc++;
            n_del++;
            hs_times.push_back(cyc);
        end
        if (pop && src_q.size() != 0) model_take(src_q.pop_front());
    endtask

    // Reset asserted between edges; checks that it acts immediately.
    task automatic do_reset();
        drive_fifo();
        rd_rst = 1'b1;
        #1;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_data", {24'd0, m_data}, 32'd0);
        check("rst_cnt", {28'd0, byte_cnt}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
`ifdef PACK_PARITY_EN
        check("rst_par", {31'd0, m_par}, 32'd0);
`endif
        model_clear();
        @(posedge rd_clk);
        #1;
        check("rst_hold_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rd_rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        gap = 1'b0;
        dut_byte = '0;
        model_clear();
        rd_rst = 1'b1;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_data = 4'h0;
        #3;
        check("init_valid", {31'd0, m_valid}, 32'd0);
        check("init_data", {24'd0, m_data}, 32'd0);
        check("init_cnt", {28'd0, byte_cnt}, 32'd0);
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;

        // 0x3,0xA -> 0xA3 for exactly one cycle
        m_ready = 1'b1;
        src_q.push_back(4'h3);
        src_q.push_back(4'hA);
        repeat (6) cycle();
        check("t029_byte", {24'd0, dut_byte}, 32'hA3);
        check("t029_n", 32'(n_del), 32'd1);
        check("t029_cnt", {28'd0, byte_cnt}, 32'd1);

        // stall with m_ready=0: 0x21 held, 0x4 stays in the FIFO
        do_reset();
        m_ready = 1'b0;
        src_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        repeat (8) cycle();
        check("t030_hold", {24'd0, m_data}, 32'h21);
        check("t030_left", 32'(src_q.size()), 32'd1);
        m_ready = 1'b1;
        repeat (8) cycle();
        check("t030_last", {24'd0, dut_byte}, 32'h43);
        check("t030_n", 32'(n_del), 32'd2);

        // empty gap between nibbles
        do_reset();
        src_q.push_back(4'h5);
        repeat (11) cycle();
        src_q.push_back(4'h6);
        repeat (5) cycle();
        check("t031_byte", {24'd0, dut_byte}, 32'h65);
        check("t031_n", 32'(n_del), 32'd1);

        // reset while a low nibble is held
        do_reset();
        src_q.push_back(4'h7);
        repeat (2) cycle();
        src_q.push_back(4'h8);
        src_q.push_back(4'h9);
        do_reset();
        repeat (6) cycle();
        check("t032_byte", {24'd0, dut_byte}, 32'h98);
        check("t032_cnt", {28'd0, byte_cnt}, 32'd1);

        // 17 back-to-back bytes: counter wraps, bytes every second cycle
        do_reset();
        for (int i = 0; i < 34; i++) src_q.push_back(4'($urandom));
        repeat (40) cycle();
        check("t033_n", 32'(n_del), 32'd17);
        check("t033_cnt", {28'd0, byte_cnt}, 32'd1);
        for (int i = 1; i < hs_times.size(); i++)
            check("t033_space", 32'(hs_times[i] - hs_times[i-1]), 32'd2);

        // byte 0x07 (parity 1 when enabled)
        do_reset();
        src_q.push_back(4'h7);
        src_q.push_back(4'h0);
        repeat (5) cycle();
        check("t034_byte", {24'd0, dut_byte}, 32'h07);

        // random traffic, stalls, gaps and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if (src_q.size() < 8 && $urandom_range(0, 1) == 1)
                src_q.push_back(4'($urandom));
            m_ready = ($urandom_range(0, 2) != 0);
            gap     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end
        gap = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_nibble_packer
`default_nettype wire

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the delivered-byte counter.
REQ-002 SHALL have port rd_clk  input  1  sole clock, read-side domain of the async FIFO.
REQ-003 SHALL have port rd_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port fifo_empty  input  1  FIFO empty flag, synchronous to rd_clk.
REQ-005 SHALL have port fifo_data  input  4  FIFO read data, valid in the same cycle whenever fifo_empty=0 (show-ahead).
REQ-006 SHALL have port fifo_rd_en  output  1  pop strobe to FIFO, combinational.
REQ-007 SHALL have port m_valid  output  1  output byte valid, registered.
REQ-008 SHALL have port m_ready  input  1  downstream accept.
REQ-009 SHALL have port m_data  output  8  packed byte, registered.
REQ-010 SHALL have port byte_cnt  output  CNT_W  count of accepted bytes, registered.
REQ-011 SHALL have port m_par  output  1  even parity of m_data, present only under PACK_PARITY_EN.

Function
REQ-012 SHALL implement a two-state FSM: S_LO (awaiting low nibble) and S_HI (low nibble held, awaiting high nibble).
REQ-013 SHALL drive fifo_rd_en = ~fifo_empty & (S_LO | (S_HI & (~m_valid | m_ready))); never pop while fifo_empty=1.
REQ-014 In S_LO on pop: SHALL capture fifo_data into lo_reg and go to S_HI next cycle.
REQ-015 In S_HI on pop: SHALL load m_data <= {fifo_data, lo_reg}, set m_valid=1, and return to S_LO, all on the same edge.
REQ-016 A handshake occurs when m_valid & m_ready; m_valid SHALL clear on that edge unless a new byte loads on the same edge, in which case it stays 1.
REQ-017 While m_valid=1 & m_ready=0, m_data SHALL remain stable; S_LO pops SHALL still proceed, and S_HI SHALL stall.
REQ-018 Sustained throughput SHALL be one byte per two rd_clk cycles with FIFO non-empty and m_ready=1; first byte m_valid rises on the edge that pops the second nibble.
REQ-019 byte_cnt SHALL increment by 1 on each handshake and wrap from 2^CNT_W-1 to 0.
REQ-020 Nibble order SHALL be first popped = m_data[3:0], second = m_data[7:4]; no nibble lost or duplicated under any stall pattern.
REQ-021 fifo_empty asserting between nibbles SHALL hold S_HI with lo_reg intact indefinitely.

Reset
REQ-022 rd_rst=1 SHALL immediately force state=S_LO, lo_reg=0, m_valid=0, m_data=0, byte_cnt=0, m_par=0.
REQ-023 Reset mid-byte SHALL discard the held low nibble; the first pop after release is treated as a low nibble.
REQ-024 fifo_rd_en SHALL be 0 while rd_rst=1.

Configuration
REQ-025 Macro PACK_PARITY_EN defined: m_par exists and is registered with m_data as even parity over the 8 bits (XOR of all bits).
REQ-026 Macro PACK_PARITY_EN undefined: m_par port and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Shared package fifo_pkg SHALL hold NIB_W=4, BYTE_W=8 and the FSM state encoding (S_LO=0, S_HI=1).
REQ-028 SHALL be a single module with no sub-module; the FIFO instance is external.

Verification
REQ-029 Nibbles 0x3,0xA with m_ready=1 -> m_data=0xA3, m_valid one cycle, byte_cnt=1, m_par=0.
REQ-030 Nibbles 0x1,0x2,0x3,0x4 with m_ready=0 -> 0x21 held, fifo_rd_en low in S_HI after 0x3 popped; m_ready=1 -> 0x21 then 0x43 delivered.
REQ-031 Nibble 0x5, fifo_empty=1 for 10 cycles, then 0x6 -> m_data=0x65, no spurious m_valid during the gap.
REQ-032 rd_rst pulse after nibble 0x7, then 0x8,0x9 -> m_data=0x98, byte_cnt=1, nibble 0x7 discarded.
REQ-033 CNT_W=4, 17 bytes streamed with m_ready=1 -> byte_cnt wraps to 1; back-to-back bytes spaced 2 cycles.
REQ-034 PACK_PARITY_EN defined, byte 0x07 -> m_par=1; build without macro compiles and passes REQ-029.
